// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB-first frames, valid/ready holding register.
// A 2-flop synchronizer feeds all decisions. The receiver reports framing and overrun errors.
// Optional macro UART_RX_PARITY_EN adds a parity bit after the data bits. It also enables
// parity_err. When the macro is undefined, frames are 10 bits and parity_err is tied low.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx: CLKS_PER_BIT must be >= 4 and PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 pend;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  assign rx_s = sync[1];

  // Two-flop synchronizer for the asynchronous serial input; resets to the idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx};
  end

  // Frame FSM, delivery into the holding register and one-cycle error pulses.
  // A good stop bit only raises pend. The load or overrun decision happens on the next
  // edge, so that it sees the consumer handshake of that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_WAIT_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      pend      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (pend) begin
        pend <= 1'b0;
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        S_WAIT_IDLE: if (rx_s) begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        S_IDLE: if (!rx_s) begin
          state <= S_START;
          cnt   <= '0;
        end
        S_START: if (cnt == HALF_M1) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt <= cnt + CW'(1);
        end
        S_DATA: if (cnt == FULL_M1) begin
          cnt     <= '0;
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + IW'(1);
          if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (cnt == FULL_M1) begin
          cnt     <= '0;
          par_bit <= rx_s;
          state   <= S_STOP;
        end else begin
          cnt <= cnt + CW'(1);
        end
`endif
        S_STOP: if (cnt == FULL_M1) begin
          cnt <= '0;
          if (!rx_s) begin
            frame_err <= 1'b1;
            state     <= S_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if ((^{shreg, par_bit}) != 1'(PARITY_ODD)) begin
            parity_err <= 1'b1;
            state      <= S_IDLE;
`endif
          end else begin
            pend  <= 1'b1;
            state <= S_IDLE;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: begin
          state <= S_WAIT_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned PODD = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_ODD(PODD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model state: bytes the consumer should see, expected error pulse totals
  logic [7:0]  exp_q[$];
  int unsigned exp_fe = 0, exp_ov = 0, exp_pe = 0;

  // observed at the consumer side
  logic [7:0]  got_q[$];
  int unsigned fe_seen = 0, ov_seen = 0, pe_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // sample away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err)  fe_seen++;
      if (overrun)    ov_seen++;
      if (parity_err) pe_seen++;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ 1'(PODD);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

  // frame-level expectation for a consumer that is always ready
  task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
`ifdef UART_RX_PARITY_EN
    if (!stop_b) exp_fe++;
    else if (par_b != good_par(d)) exp_pe++;
    else exp_q.push_back(d);
`else
    if (!stop_b) exp_fe++;
    else exp_q.push_back(d);
`endif
  endtask

  task automatic check_all(input string tag);
    check({tag, "_fe"}, fe_seen, exp_fe);
    check({tag, "_ov"}, ov_seen, exp_ov);
    check({tag, "_pe"}, pe_seen, exp_pe);
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    logic [7:0]  d;
    logic        sb, pb;

    reset = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    tick(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data",  rx_data,  0);
    check("rst_flags", {frame_err, overrun, parity_err}, 0);
    reset = 1'b0;
    tick(5);

    // first frame: latency from the start edge to rx_valid
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, good_par(8'hA5));
      begin
        while (!rx_valid && lat < 300) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("a5_latency_window", (lat >= 150 && lat <= 160), 1);
    model_frame(8'hA5, 1'b1, good_par(8'hA5));
    tick(20);
    check_all("a5");

    // short glitch is rejected, then a real frame
    rx = 1'b0; tick(5); rx = 1'b1; tick(40);
    check_all("glitch");
    send_frame(8'h3C, 1'b1, good_par(8'h3C));
    model_frame(8'h3C, 1'b1, good_par(8'h3C));
    tick(20);
    check_all("glitch_3c");

    // framing error with a long break; no retrigger while low
    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    rx = 1'b0; tick(40); rx = 1'b1; tick(20);
    exp_fe++;
    check_all("break");
    send_frame(8'h55, 1'b1, good_par(8'h55));
    model_frame(8'h55, 1'b1, good_par(8'h55));
    tick(20);
    check_all("after_break");

    // overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, good_par(8'h11)); tick(20);
    send_frame(8'h22, 1'b1, good_par(8'h22)); tick(20);
    exp_ov++;
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    check("ovr_valid_cleared", rx_valid, 0);
    check("ovr_data_held", rx_data, 8'h11);
    rx_ready = 1'b1;
    tick(5);
    check_all("overrun");

    // reset mid-frame while a byte is being held
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, good_par(8'h5A)); tick(20);
    check("prerst_valid", rx_valid, 1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1; tick(5);
    reset = 1'b1; #1;
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_flags", {frame_err, overrun, parity_err}, 0);
    tick(CPB - 5);
    for (int i = 4; i < 8; i++) send_bit(1'b0);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    rx = 1'b1; tick(4);
    reset = 1'b0; rx_ready = 1'b1;
    tick(30);
    send_frame(8'hF0, 1'b1, good_par(8'hF0));
    model_frame(8'hF0, 1'b1, good_par(8'hF0));
    tick(20);
    check_all("reset_f0");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b0);
    tick(20);
    check_all("par_bad");
    send_frame(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b1, 1'b1);
    tick(20);
    check_all("par_good");
`endif

    // randomized frames with occasional bad stop/parity bits
    for (int k = 0; k < 16; k++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      pb = good_par(d);
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 5) == 0) pb = ~pb;
`endif
      send_frame(d, sb, pb);
      model_frame(d, sb, pb);
      tick(20 + $urandom_range(0, 30));
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
